// File: rtl/abejaruco_pkg.sv
// Shared core parameters and writeback requester ids.
// Used by the register-file write scheduler and its arbiter.
package abejaruco_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int NUM_REGS    = 32;
  localparam int INDEX_WIDTH = $clog2(NUM_REGS);

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (ALU vs MEM writeback).
// Grants are combinational; last_grant resets to MEM.
module rr_arbiter2
  import abejaruco_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  logic last_grant;

  assign gnt_alu = !reset && req_alu &&
                   (!req_mem || last_grant == GRANT_MEM);
  assign gnt_mem = !reset && req_mem &&
                   (!req_alu || last_grant == GRANT_ALU);

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= GRANT_MEM;
    else if (gnt_alu)
      last_grant <= GRANT_ALU;
    else if (gnt_mem)
      last_grant <= GRANT_MEM;
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the regfile write port between ALU and load writeback.
// Optional trace: define REGFILE_SCHED_TRACE_EN.
module regfile_write_scheduler #(
  parameter int WORD_SIZE   = abejaruco_pkg::WORD_SIZE,
  parameter int NUM_REGS    = abejaruco_pkg::NUM_REGS,
  parameter int INDEX_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [INDEX_WIDTH-1:0] alu_idx,
  input  logic [WORD_SIZE-1:0]   alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [INDEX_WIDTH-1:0] mem_idx,
  input  logic [WORD_SIZE-1:0]   mem_data,
  output logic                   mem_ready,
  input  logic                   issue_valid,
  input  logic [INDEX_WIDTH-1:0] issue_idx,
  input  logic [INDEX_WIDTH-1:0] read_idx_1,
  input  logic [INDEX_WIDTH-1:0] read_idx_2,
  output logic                   busy_1,
  output logic                   busy_2,
  output logic                   rf_write_enable,
  output logic [INDEX_WIDTH-1:0] rf_write_idx,
  output logic [WORD_SIZE-1:0]   rf_write_data
);

  import abejaruco_pkg::*;

  logic                   alu_gnt;
  logic                   mem_gnt;
  logic                   any_gnt;
  logic [INDEX_WIDTH-1:0] gnt_idx;
  logic [WORD_SIZE-1:0]   gnt_data;
  logic [NUM_REGS-1:0]    pending;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (alu_valid),
    .req_mem (mem_valid),
    .gnt_alu (alu_gnt),
    .gnt_mem (mem_gnt)
  );

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;
  assign any_gnt   = alu_gnt | mem_gnt;
  assign gnt_idx   = alu_gnt ? alu_idx  : mem_idx;
  assign gnt_data  = alu_gnt ? alu_data : mem_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_idx    <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= any_gnt && (gnt_idx != '0);
      if (any_gnt) begin
        rf_write_idx  <= gnt_idx;
        rf_write_data <= gnt_data;
      end
    end
  end

  // Set is ordered after clear so a newer producer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (any_gnt)
        pending[gnt_idx] <= 1'b0;
      if (issue_valid)
        pending[issue_idx] <= 1'b1;
      pending[0] <= 1'b0;
    end
  end

  assign busy_1 = pending[read_idx_1];
  assign busy_2 = pending[read_idx_2];

`ifdef REGFILE_SCHED_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (any_gnt)
        $display("[SCHED] %s idx=%0d data=%b",
                 alu_gnt ? "ALU" : "MEM", gnt_idx, gnt_data);
      if (any_gnt && gnt_idx != '0 &&
          !(issue_valid && issue_idx == gnt_idx))
        $display("[SCHED] clear pending[%0d]", gnt_idx);
      if (issue_valid && issue_idx != '0)
        $display("[SCHED] set pending[%0d]", issue_idx);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: vector table plus expected-write queue.
// Hand sequences cover reset during an in-flight write.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_idx, mem_idx, issue_idx;
  logic [4:0]  read_idx_1, read_idx_2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy_1, busy_2;
  logic        rf_write_enable;
  logic [4:0]  rf_write_idx;
  logic [31:0] rf_write_data;

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_idx         (alu_idx),
    .alu_data        (alu_data),
    .alu_ready       (alu_ready),
    .mem_valid       (mem_valid),
    .mem_idx         (mem_idx),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .issue_valid     (issue_valid),
    .issue_idx       (issue_idx),
    .read_idx_1      (read_idx_1),
    .read_idx_2      (read_idx_2),
    .busy_1          (busy_1),
    .busy_2          (busy_2),
    .rf_write_enable (rf_write_enable),
    .rf_write_idx    (rf_write_idx),
    .rf_write_data   (rf_write_data)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ai;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mi;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ii;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ea;
    logic        em;
    logic        eb1;
    logic        eb2;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  vec_t        tbl[17];
  vec_t        v;
  wr_t         q[$];
  logic [4:0]  hold_idx;
  logic [31:0] hold_data;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_wr(input string nm);
    wr_t w;
    if (q.size() == 0) begin
      chk({nm, ".queue_empty"}, 1, 0);
    end else begin
      w = q.pop_front();
      chk({nm, ".we"}, rf_write_enable, w.en);
      chk({nm, ".widx"}, rf_write_idx, w.idx);
      chk({nm, ".wdata"}, rf_write_data, w.data);
    end
  endtask

  task automatic apply(input vec_t x, input string nm);
    alu_valid   = x.av;
    alu_idx     = x.ai;
    alu_data    = x.ad;
    mem_valid   = x.mv;
    mem_idx     = x.mi;
    mem_data    = x.md;
    issue_valid = x.iv;
    issue_idx   = x.ii;
    read_idx_1  = x.r1;
    read_idx_2  = x.r2;
    #1;
    chk({nm, ".alu_ready"}, alu_ready, x.ea);
    chk({nm, ".mem_ready"}, mem_ready, x.em);
    chk({nm, ".busy_1"}, busy_1, x.eb1);
    chk({nm, ".busy_2"}, busy_2, x.eb2);
    if (x.ea) begin
      hold_idx  = x.ai;
      hold_data = x.ad;
      q.push_back('{x.ai != 0, x.ai, x.ad});
    end else if (x.em) begin
      hold_idx  = x.mi;
      hold_data = x.md;
      q.push_back('{x.mi != 0, x.mi, x.md});
    end else begin
      q.push_back('{1'b0, hold_idx, hold_data});
    end
    @(posedge clk);
    #1;
    check_wr(nm);
  endtask

  initial begin
    // contention right after reset: ALU, MEM, ALU, MEM
    for (int i = 0; i < 4; i++)
      tbl[i] = '{1, 3, 32'h1111_0003, 1, 4, 32'h2222_0004,
                 0, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, 0, 0};
    tbl[4]  = '{1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 7, 32'h0000_0077, 0, 0, 7, 0, 0, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0};
    tbl[10] = '{1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 9, 1, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 9, 0, 1, 0, 1};
    tbl[15] = '{1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 9, 1, 0, 0, 0};
    tbl[16] = '{1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 9, 0, 1, 0, 0};

    reset       = 1'b1;
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
    alu_idx     = '0;
    mem_idx     = '0;
    issue_idx   = '0;
    alu_data    = '0;
    mem_data    = '0;
    read_idx_1  = 5'd7;
    read_idx_2  = 5'd9;
    hold_idx    = '0;
    hold_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_idx   = 5'd3;
    mem_idx   = 5'd4;
    #1;
    chk("rst.alu_ready", alu_ready, 0);
    chk("rst.mem_ready", mem_ready, 0);
    chk("rst.we", rf_write_enable, 0);
    chk("rst.widx", rf_write_idx, 0);
    chk("rst.wdata", rf_write_data, 0);
    chk("rst.busy_1", busy_1, 0);
    chk("rst.busy_2", busy_2, 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++)
      apply(tbl[i], $sformatf("row%0d", i));

    // reset while a latched write is in flight
    v = '{0, 0, 0, 0, 0, 0, 1, 20, 20, 0, 0, 0, 0, 0};
    apply(v, "mid.issue");
    v = '{1, 12, 32'hC0DE_000C, 0, 0, 0, 0, 0, 20, 0, 1, 0, 1, 0};
    apply(v, "mid.grant");
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_idx   = 5'd13;
    #1;
    chk("mid.rst.alu_ready", alu_ready, 0);
    chk("mid.rst.mem_ready", mem_ready, 0);
    chk("mid.rst.busy_1", busy_1, 1);
    @(posedge clk);
    #1;
    chk("mid.after.we", rf_write_enable, 0);
    chk("mid.after.widx", rf_write_idx, 0);
    chk("mid.after.wdata", rf_write_data, 0);
    chk("mid.after.busy_1", busy_1, 0);
    chk("mid.after.alu_ready", alu_ready, 0);
    chk("mid.after.mem_ready", mem_ready, 0);
    reset     = 1'b0;
    hold_idx  = '0;
    hold_data = '0;
    v = '{1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 20, 0, 1, 0, 0, 0};
    apply(v, "post.rst.alu_first");
    v = '{0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1, 0, 0};
    apply(v, "post.rst.mem");
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
